select_top_k_stream: RTL

Parametrised streaming top-K selector that is the successor of the fixed 24-input / 6-group selector. It accepts a frame of up to GROUPS×DEPTH unsigned samples over a valid/ready input stream and builds per-group sorted lists by insertion. It then emits the K largest values (or smallest, per mode) in order, each tagged with its arrival position, over a valid/ready output stream. It sits between the sample front-end and the downstream ranking/report logic.

---
 rtl/select_top_pkg.sv | 25 ++
 rtl/sorted_insert_group.sv | 99 +++++++++
 rtl/select_top_k_stream.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/select_top_pkg.sv
// Shared types and ranking rules for the streaming top-K selector.
package select_top_pkg;

    typedef enum logic [1:0] {
        LOAD,
        SELECT,
        EMIT
    } state_t;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

    // Strict ordering on value alone; equal values never outrank each other.
    function automatic logic outranks(input logic [31:0] a, input logic [31:0] b, input logic mode);
        return (mode == MODE_MIN) ? (a < b) : (a > b);
    endfunction

    // Cross-group ordering: value first, then the lower group index wins a tie.
    function automatic logic ranks_first(input logic [31:0] a_val, input logic [7:0] a_grp,
                                         input logic [31:0] b_val, input logic [7:0] b_grp,
                                         input logic mode);
        return outranks(a_val, b_val, mode) || ((a_val == b_val) && (a_grp < b_grp));
    endfunction

endpackage

// File: rtl/sorted_insert_group.sv
// One sorted group: insertion-sorted shift array with empty flags, stored
// arrival indices and a read pointer that walks the list from its head.
module sorted_insert_group
    import select_top_pkg::*;
#(
    parameter int DATA_W = 13,
    parameter int DEPTH  = 4,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              mode,
    input  logic              ins_valid,
    input  logic [DATA_W-1:0] ins_data,
    input  logic [IDX_W-1:0]  ins_index,
    input  logic              ptr_rst,
    input  logic              adv,
    output logic [DATA_W-1:0] head_data,
    output logic [IDX_W-1:0]  head_index,
    output logic              exhausted
);

    localparam int PW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] val     [DEPTH];
    logic [IDX_W-1:0]  idx     [DEPTH];
    logic [DATA_W-1:0] val_nxt [DEPTH];
    logic [IDX_W-1:0]  idx_nxt [DEPTH];
    logic [DEPTH-1:0]  full;
    logic [DEPTH-1:0]  full_nxt;
    logic [DEPTH-1:0]  take;
    logic [PW-1:0]     ptr;

    // Insertion point: first slot that is empty or strictly outranked by the new
    // sample, so equal values land behind earlier arrivals. Slots from there shift down.
    always_comb begin
        val_nxt  = val;
        idx_nxt  = idx;
        full_nxt = full;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            take[i] = !full[i] || outranks(32'(ins_data), 32'(val[i]), mode);
        end
        if (take[0]) begin
            val_nxt[0]  = ins_data;
            idx_nxt[0]  = ins_index;
            full_nxt[0] = 1'b1;
        end
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (take[i] && !take[i-1]) begin
                val_nxt[i]  = ins_data;
                idx_nxt[i]  = ins_index;
                full_nxt[i] = 1'b1;
            end else if (take[i]) begin
                val_nxt[i]  = val[i-1];
                idx_nxt[i]  = idx[i-1];
                full_nxt[i] = full[i-1];
            end
        end
    end

    // Occupancy flags and read pointer; a cleared group has every slot empty.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            full <= '0;
            ptr  <= '0;
        end else begin
            if (ins_valid) full <= full_nxt;
            if (ptr_rst) begin
                ptr <= '0;
            end else if (adv) begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    // Payload storage; contents are only meaningful where the full flag is set.
    always_ff @(posedge clk) begin
        if (ins_valid) begin
            val <= val_nxt;
            idx <= idx_nxt;
        end
    end

    // Head of the remaining list; exhausted once the pointer reaches an empty slot or the end.
    always_comb begin
        head_data  = '0;
        head_index = '0;
        exhausted  = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ptr == PW'(i)) begin
                head_data  = val[i];
                head_index = idx[i];
                exhausted  = !full[i];
            end
        end
    end

endmodule

// File: rtl/select_top_k_stream.sv
// Streaming top-K selector: loads a frame into sorted groups, then merges the
// group heads through a comparator tree and emits the K best with arrival index.
module select_top_k_stream
    import select_top_pkg::*;
#(
    parameter int DATA_W = 13,
    parameter int GROUPS = 6,
    parameter int DEPTH  = 4,
    parameter int TOP_K  = 6,
    localparam int IDX_W = $clog2(GROUPS * DEPTH)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] In_Data,
    input  logic              In_Last,
    input  logic              Mode,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Out_Data,
    output logic [IDX_W-1:0]  Out_Index,
    output logic              Out_Last,
    output logic              Busy
);

    localparam int TOTAL = GROUPS * DEPTH;
    localparam int GW    = $clog2(GROUPS);
    localparam int SW    = $clog2(DEPTH);
    localparam int RW    = IDX_W + 1;
    localparam int NN    = 2 * GROUPS - 1;

    state_t            state;
    logic [IDX_W-1:0]  cnt;
    logic [GW-1:0]     grp;
    logic [SW-1:0]     slot;
    logic [RW-1:0]     rem;
    logic              mode_q;

    logic              frame_mode;
    logic              in_fire;
    logic              closing;
    logic              do_load;
    logic              drain_last;
    logic              ptr_rst;
    logic [RW-1:0]     n_beats;
    logic [RW-1:0]     n_results;

    logic [DATA_W-1:0] head_data  [GROUPS];
    logic [IDX_W-1:0]  head_index [GROUPS];
    logic [GROUPS-1:0] exhausted;
    logic [GROUPS-1:0] ins_valid;
    logic [GROUPS-1:0] adv;

    logic [DATA_W-1:0] node_val [NN];
    logic [IDX_W-1:0]  node_idx [NN];
    logic [GW-1:0]     node_grp [NN];
    logic              node_ok  [NN];

    assign frame_mode = Busy ? mode_q : Mode;
    assign in_fire    = In_Valid && In_Ready;
    assign closing    = In_Last || (cnt == IDX_W'(TOTAL - 1));
    assign ptr_rst    = in_fire && closing;
    assign drain_last = (state == EMIT) && Out_Valid && Out_Ready && Out_Last;
    assign do_load    = (state == SELECT) ||
                        ((state == EMIT) && (!Out_Valid || Out_Ready) && (rem != '0));
    assign n_beats    = RW'(cnt) + 1'b1;
    assign n_results  = (n_beats > RW'(TOP_K)) ? RW'(TOP_K) : n_beats;

    for (genvar g = 0; g < GROUPS; g++) begin : g_group
        assign ins_valid[g] = in_fire && (grp == GW'(g));
        assign adv[g]       = do_load && (node_grp[0] == GW'(g));

        sorted_insert_group #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .IDX_W  (IDX_W)
        ) u_group (
            .clk        (Clk),
            .rst_n      (Reset),
            .clear      (drain_last),
            .mode       (frame_mode),
            .ins_valid  (ins_valid[g]),
            .ins_data   (In_Data),
            .ins_index  (cnt),
            .ptr_rst    (ptr_rst),
            .adv        (adv[g]),
            .head_data  (head_data[g]),
            .head_index (head_index[g]),
            .exhausted  (exhausted[g])
        );
    end

    // Heap-ordered reduction tree: leaves are group heads, node 0 is the winner.
    // Leaf order in the heap is not group order, so ties resolve on the carried group index.
    always_comb begin
        node_val = '{default: '0};
        node_idx = '{default: '0};
        node_grp = '{default: '0};
        node_ok  = '{default: 1'b0};
        for (int unsigned g = 0; g < GROUPS; g++) begin
            node_val[GROUPS-1+g] = head_data[g];
            node_idx[GROUPS-1+g] = head_index[g];
            node_grp[GROUPS-1+g] = GW'(g);
            node_ok[GROUPS-1+g]  = !exhausted[g];
        end
        for (int unsigned k = 0; k < GROUPS - 1; k++) begin
            int unsigned n;
            int unsigned l;
            int unsigned r;
            logic        pick_l;
            n = GROUPS - 2 - k;
            l = 2 * n + 1;
            r = 2 * n + 2;
            pick_l = node_ok[l] && (!node_ok[r] ||
                     ranks_first(32'(node_val[l]), 8'(node_grp[l]),
                                 32'(node_val[r]), 8'(node_grp[r]), mode_q));
            node_val[n] = pick_l ? node_val[l] : node_val[r];
            node_idx[n] = pick_l ? node_idx[l] : node_idx[r];
            node_grp[n] = pick_l ? node_grp[l] : node_grp[r];
            node_ok[n]  = node_ok[l] || node_ok[r];
        end
    end

    // Frame control FSM with registered handshake and result outputs.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= LOAD;
            In_Ready  <= 1'b0;
            Out_Valid <= 1'b0;
            Out_Data  <= '0;
            Out_Index <= '0;
            Out_Last  <= 1'b0;
            Busy      <= 1'b0;
            cnt       <= '0;
            grp       <= '0;
            slot      <= '0;
            rem       <= '0;
            mode_q    <= MODE_MAX;
        end else begin
            case (state)
                LOAD: begin
                    In_Ready <= 1'b1;
                    if (in_fire) begin
                        Busy <= 1'b1;
                        if (!Busy) mode_q <= Mode;
                        cnt <= cnt + 1'b1;
                        if (slot == SW'(DEPTH - 1)) begin
                            slot <= '0;
                            grp  <= grp + 1'b1;
                        end else begin
                            slot <= slot + 1'b1;
                        end
                        if (closing) begin
                            state    <= SELECT;
                            In_Ready <= 1'b0;
                            rem      <= n_results;
                            cnt      <= '0;
                            grp      <= '0;
                            slot     <= '0;
                        end
                    end
                end
                SELECT: begin
                    state <= EMIT;
                end
                EMIT: begin
                    if (drain_last) begin
                        state     <= LOAD;
                        Out_Valid <= 1'b0;
                        Out_Last  <= 1'b0;
                        Busy      <= 1'b0;
                        In_Ready  <= 1'b1;
                    end else if (!do_load && Out_Valid && Out_Ready) begin
                        Out_Valid <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase

            if (do_load) begin
                Out_Valid <= 1'b1;
                Out_Data  <= node_val[0];
                Out_Index <= node_idx[0];
                Out_Last  <= (rem == RW'(1));
                rem       <= rem - 1'b1;
            end
        end
    end

endmodule
